// File: rtl/cook_countdown.sv
// Kitchen cook timer: loads a BCD mm:ss-style seconds count (00-59), counts down on
// one-second ticks with pause/resume, then raises an alarm for ALARM_TICKS ticks.
module cook_countdown #(
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic [3:0] load_ones,
  input  logic [3:0] load_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       alarm
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned ACNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [DIGIT_W-1:0]  ones_next, tens_next;
  logic [ACNT_W-1:0]   alarm_cnt, alarm_cnt_next, alarm_cnt_inc;
  logic                running_next, alarm_next;
  logic                start_prev, stop_prev;
  logic                start_edge, stop_edge;
  logic [DIGIT_W-1:0]  ld_ones, ld_tens;
  logic                ld_nonzero;
  logic [DIGIT_W-1:0]  dec_ones, dec_tens;
  logic                count_nonzero, dec_zero;

  // Button edge detection, clamped load digits and the BCD decrement result
  always_comb begin
    start_edge    = start_btn & ~start_prev;
    stop_edge     = stop_btn  & ~stop_prev;
    ld_ones       = (load_ones > 4'd9) ? 4'd9 : load_ones;
    ld_tens       = (load_tens > 4'd5) ? 4'd5 : load_tens;
    ld_nonzero    = (ld_ones != 4'd0) || (ld_tens != 4'd0);
    count_nonzero = (ones != 4'd0) || (tens != 4'd0);
    if (ones != 4'd0) begin
      dec_ones = ones - 4'd1;
      dec_tens = tens;
    end else begin
      dec_ones = 4'd9;
      dec_tens = tens - 4'd1;
    end
    dec_zero      = (dec_ones == 4'd0) && (dec_tens == 4'd0);
    alarm_cnt_inc = alarm_cnt + ACNT_W'(1);
  end

  // Next-state and next-output logic; stop edges always win over start edges
  always_comb begin
    state_next     = state;
    ones_next      = ones;
    tens_next      = tens;
    alarm_cnt_next = alarm_cnt;

    case (state)
      S_IDLE: begin
        if (start_edge && !stop_edge && ld_nonzero) state_next = S_RUN;
      end
      S_RUN: begin
        if (tick && count_nonzero) begin
          ones_next = dec_ones;
          tens_next = dec_tens;
          if (dec_zero) begin
            state_next     = S_ALARM;
            alarm_cnt_next = '0;
          end else if (stop_edge) begin
            state_next = S_PAUSE;
          end
        end else if (stop_edge) begin
          state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop_edge)       state_next = S_IDLE;
        else if (start_edge) state_next = S_RUN;
      end
      S_ALARM: begin
        ones_next = '0;
        tens_next = '0;
        if (stop_edge) begin
          state_next = S_IDLE;
        end else if (tick) begin
          alarm_cnt_next = alarm_cnt_inc;
          if (alarm_cnt_inc == ACNT_W'(ALARM_TICKS)) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // IDLE (and the edge entering RUN from IDLE) tracks the clamped load value
    if (state_next == S_IDLE || state == S_IDLE) begin
      ones_next = ld_ones;
      tens_next = ld_tens;
    end

    running_next = (state_next == S_RUN);
    alarm_next   = (state_next == S_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ones       <= '0;
      tens       <= '0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      alarm_cnt  <= '0;
      start_prev <= 1'b0;
      stop_prev  <= 1'b0;
    end else begin
      state      <= state_next;
      ones       <= ones_next;
      tens       <= tens_next;
      running    <= running_next;
      alarm      <= alarm_next;
      alarm_cnt  <= alarm_cnt_next;
      start_prev <= start_btn;
      stop_prev  <= stop_btn;
    end
  end

endmodule

// File: tb/tb_cook_countdown.sv
// Scoreboard bench for cook_countdown: an integer-seconds reference model predicts
// each cycle's outputs; a monitor compares them one clock edge later.
module tb_cook_countdown;

  localparam int unsigned ALARM_TICKS = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic [3:0] load_ones = 4'd0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] ones, tens;
  logic       running, alarm;

  cook_countdown #(.ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn), .stop_btn(stop_btn),
    .load_ones(load_ones), .load_tens(load_tens),
    .ones(ones), .tens(tens), .running(running), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];

  // Reference model: remaining time as plain seconds, mode 0=idle 1=run 2=pause 3=alarm
  int m_mode = 0;
  int m_rem  = 0;
  int m_acnt = 0;
  bit m_pstart = 1'b0;
  bit m_pstop  = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_acnt = 0; m_pstart = 1'b0; m_pstop = 1'b0;
  endtask

  task automatic model_step();
    int ld;
    bit se, pe;
    ld = ((load_tens > 4'd5) ? 5 : int'(load_tens)) * 10 + ((load_ones > 4'd9) ? 9 : int'(load_ones));
    se = start_btn && !m_pstart;
    pe = stop_btn && !m_pstop;
    m_pstart = start_btn;
    m_pstop  = stop_btn;
    case (m_mode)
      0: if (!pe && se && ld != 0) begin m_mode = 1; m_rem = ld; end
      1: begin
        if (tick && m_rem > 0) m_rem--;
        if (m_rem == 0) begin m_mode = 3; m_acnt = 0; end
        else if (pe) m_mode = 2;
      end
      2: if (pe) m_mode = 0; else if (se) m_mode = 1;
      default: begin
        if (pe) m_mode = 0;
        else if (tick) begin
          m_acnt++;
          if (m_acnt == int'(ALARM_TICKS)) m_mode = 0;
        end
      end
    endcase
    if (m_mode == 0) m_rem = ld;
    exp_q.push_back({4'(m_rem / 10), 4'(m_rem % 10), (m_mode == 1), (m_mode == 3)});
  endtask

  task automatic step(input bit tk, input bit sb, input bit pb, input int lo, input int lt);
    @(negedge clk);
    tick = tk; start_btn = sb; stop_btn = pb;
    load_ones = 4'(lo); load_tens = 4'(lt);
    model_step();
  endtask

  task automatic tsk(input bit tk, input bit sb, input bit pb);
    step(tk, sb, pb, int'(load_ones), int'(load_tens));
  endtask

  task automatic go(input int lo, input int lt);
    step(0, 0, 0, lo, lt);
    step(0, 1, 0, lo, lt);
    step(0, 0, 0, lo, lt);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({tens, ones, running, alarm} !== 10'd0) begin
      n_fail++;
      $display("FAIL %s: tens=%0d ones=%0d running=%0b alarm=%0b, required all zero",
               name, tens, ones, running, alarm);
    end
  endtask

  // Reset pulse strictly between clock edges; outputs must clear with no clock
  task automatic reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    #1 reset = 1'b0;
    model_step();
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [9:0] e, a;
      e = exp_q.pop_front();
      a = {tens, ones, running, alarm};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got tens=%0d ones=%0d running=%0b alarm=%0b, required tens=%0d ones=%0d running=%0b alarm=%0b",
                 $time, a[9:6], a[5:2], a[1], a[0], e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    model_reset();
    model_step();

    // Three-second countdown into alarm, then stop back to idle
    go(3, 0);
    repeat (3) begin tsk(1, 0, 0); tsk(0, 0, 0); end
    tsk(0, 0, 1); tsk(0, 0, 0);

    // BCD borrow, pause ignores ticks, resume without reload
    go(0, 1);
    tsk(1, 0, 0); tsk(0, 0, 1); tsk(0, 0, 0);
    repeat (3) tsk(1, 0, 0);
    tsk(0, 1, 0); tsk(0, 0, 0); tsk(1, 0, 0); tsk(0, 0, 0);
    tsk(0, 0, 1); tsk(0, 0, 0); tsk(0, 0, 1); tsk(0, 0, 0);

    // Alarm times out after ALARM_TICKS ticks; then alarm cut short by stop
    go(1, 0);
    tsk(1, 0, 0);
    repeat (ALARM_TICKS) begin tsk(1, 0, 0); tsk(0, 0, 0); end
    go(1, 0);
    tsk(1, 0, 0);
    repeat (2) begin tsk(1, 0, 0); tsk(0, 0, 0); end
    tsk(0, 0, 1); tsk(0, 0, 0);

    // Zero load ignored; out-of-range load clamped
    go(0, 0);
    step(0, 0, 0, 12, 7); step(0, 0, 0, 12, 7);

    // Tick plus stop on the same cycle, and simultaneous start/stop in idle
    go(2, 0);
    tsk(1, 0, 1); tsk(0, 0, 0); tsk(0, 1, 0); tsk(0, 0, 0);
    tsk(1, 0, 1); tsk(0, 0, 0); tsk(0, 0, 1); tsk(0, 0, 0);
    step(0, 1, 1, 5, 2); step(0, 0, 0, 5, 2);

    // Async reset mid-run at 37 with start held through release
    go(7, 3);
    tsk(0, 1, 0);
    reset_pulse();
    tsk(0, 1, 0); tsk(0, 0, 0); tsk(1, 0, 0);

    // Randomized traffic with level-held buttons and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit tk, sb, pb;
      int lo, lt;
      tk = ($urandom_range(0, 2) == 0);
      sb = ($urandom_range(0, 5) == 0) ? !start_btn : start_btn;
      pb = ($urandom_range(0, 11) == 0) ? !stop_btn : stop_btn;
      lo = int'(load_ones); lt = int'(load_tens);
      if ($urandom_range(0, 19) == 0) begin
        lo = int'($urandom_range(0, 15));
        lt = int'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else step(tk, sb, pb, lo, lt);
    end

    tsk(0, 0, 0);
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
